// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants, controller state encoding and control-bundle type
// used by the multicycle controller and its branch evaluator.
package rv32_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       ien;
        logic       pc_en;
        logic       reg_or_imm;
        logic [1:0] alu_a;
        logic       we;
        logic [2:0] ls_cntl;
        logic       flag_en;
        logic       branch_taken;
        logic       jump;
        logic       trap;
    } ctl_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator: funct3 plus ALU flags {V,C,N,Z} -> taken / illegal.
module branch_eval
    import rv32_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic [3:0] flags_i,
    output logic       taken_o,
    output logic       illegal_o
);

    logic z, n, c, v;
    assign z = flags_i[0];
    assign n = flags_i[1];
    assign c = flags_i[2];
    assign v = flags_i[3];

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = z;
            F3_BNE:  taken_o = !z;
            F3_BLT:  taken_o = n ^ v;
            F3_BGE:  taken_o = !(n ^ v);
            // C is "no borrow", so unsigned less-than is its complement
            F3_BLTU: taken_o = !c;
            F3_BGEU: taken_o = c;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB/TRAP with memory
// ready stalls; all datapath enables are decoded from the current state.
module multicycle_controller
    import rv32_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [XLEN-1:0]     instr,
    input  logic                mem_ready,
    input  logic [4:0]          flags,
    output logic                mem_req,
    output logic                ien,
    output logic                pc_en,
    output logic [NUM_REGS-1:0] ren,
    output logic                reg_or_imm,
    output logic [1:0]          alu_mux_cntl,
    output logic                we,
    output logic [2:0]          ls_cntl,
    output logic                flag_en,
    output logic                branch_taken,
    output logic                jump,
    output logic                trap,
    output logic [2:0]          state
);

    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    state_e state_q, state_d;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [RW-1:0]       rd_idx;
    logic [NUM_REGS-1:0] ren_onehot;
    logic                br_taken, br_illegal;
    ctl_t                ctl;
    logic [NUM_REGS-1:0] ren_c;
    logic                unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd_idx = instr[7 +: RW];
    assign unused_bits = ^{instr, flags[4]};

    // Bit 0 is hardwired low so writes to x0 never produce an enable.
    assign ren_onehot[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_ren
            assign ren_onehot[gi] = (rd_idx == RW'(gi));
        end
    endgenerate

    branch_eval u_branch_eval (
        .funct3_i  (funct3),
        .flags_i   (flags[3:0]),
        .taken_o   (br_taken),
        .illegal_o (br_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctl     = '0;
        ren_c   = '0;
        case (state_q)
            S_FETCH: begin
                ctl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctl.ien = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    BRANCH: begin
                        ctl.flag_en = 1'b1;
                        state_d     = br_illegal ? S_TRAP : S_EXECUTE;
                    end
                    LOAD:  state_d = load_f3_ok(funct3)  ? S_MEM : S_TRAP;
                    STORE: state_d = store_f3_ok(funct3) ? S_MEM : S_TRAP;
                    OP, OP_IMM, LUI, AUIPC, JAL, JALR, MISC_MEM: state_d = S_EXECUTE;
                    default: state_d = S_TRAP;
                endcase
            end
            S_EXECUTE: begin
                ctl.pc_en = 1'b1;
                state_d   = S_FETCH;
                case (opcode)
                    OP: ren_c = ren_onehot;
                    OP_IMM: begin
                        ctl.reg_or_imm = 1'b1;
                        ren_c          = ren_onehot;
                    end
                    LUI: begin
                        ctl.alu_a      = ALU_A_ZERO;
                        ctl.reg_or_imm = 1'b1;
                        ren_c          = ren_onehot;
                    end
                    AUIPC: begin
                        ctl.alu_a      = ALU_A_PC;
                        ctl.reg_or_imm = 1'b1;
                        ren_c          = ren_onehot;
                    end
                    JAL, JALR: begin
                        ctl.alu_a = ALU_A_PC;
                        ctl.jump  = 1'b1;
                        ren_c     = ren_onehot;
                    end
                    BRANCH: ctl.branch_taken = br_taken;
                    default: ;
                endcase
            end
            S_MEM: begin
                ctl.mem_req    = 1'b1;
                ctl.reg_or_imm = 1'b1;
                ctl.ls_cntl    = funct3;
                ctl.we         = (opcode == STORE);
                if (mem_ready) begin
                    if (opcode == STORE) begin
                        ctl.pc_en = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d   = S_WB;
                    end
                end
            end
            S_WB: begin
                ren_c       = ren_onehot;
                ctl.ls_cntl = funct3;
                ctl.pc_en   = 1'b1;
                state_d     = S_FETCH;
            end
            S_TRAP: begin
                ctl.trap  = 1'b1;
                ctl.pc_en = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every output combinationally, so a store drops we immediately.
    assign mem_req      = ctl.mem_req      & ~rst;
    assign ien          = ctl.ien          & ~rst;
    assign pc_en        = ctl.pc_en        & ~rst;
    assign reg_or_imm   = ctl.reg_or_imm   & ~rst;
    assign alu_mux_cntl = rst ? 2'b00 : ctl.alu_a;
    assign we           = ctl.we           & ~rst;
    assign ls_cntl      = rst ? 3'b000 : ctl.ls_cntl;
    assign flag_en      = ctl.flag_en      & ~rst;
    assign branch_taken = ctl.branch_taken & ~rst;
    assign jump         = ctl.jump         & ~rst;
    assign trap         = ctl.trap         & ~rst;
    assign ren          = rst ? '0 : ren_c;
    assign state        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller plus hand-written reset sequences.
module tb_multicycle_controller;

    typedef struct packed {
        logic [2:0]  st;
        logic        mreq;
        logic        ien;
        logic        pc_en;
        logic [31:0] ren;
        logic        roi;
        logic [1:0]  alu;
        logic        we;
        logic [2:0]  ls;
        logic        fen;
        logic        bt;
        logic        jmp;
        logic        trap;
    } out_t;

    typedef struct {
        logic [31:0] instr;
        logic        rdy;
        logic [4:0]  flags;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        mem_ready;
    logic [4:0]  flags;
    logic        mem_req, ien, pc_en, reg_or_imm, we, flag_en, branch_taken, jump, trap;
    logic [31:0] ren;
    logic [1:0]  alu_mux_cntl;
    logic [2:0]  ls_cntl, state;

    out_t act;
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    multicycle_controller #(.XLEN(32), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .flags(flags),
        .mem_req(mem_req), .ien(ien), .pc_en(pc_en), .ren(ren), .reg_or_imm(reg_or_imm),
        .alu_mux_cntl(alu_mux_cntl), .we(we), .ls_cntl(ls_cntl), .flag_en(flag_en),
        .branch_taken(branch_taken), .jump(jump), .trap(trap), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {state, mem_req, ien, pc_en, ren, reg_or_imm, alu_mux_cntl, we,
                  ls_cntl, flag_en, branch_taken, jump, trap};

    function automatic out_t o(input logic [2:0] st, input logic mr, input logic ie,
                               input logic pe, input logic [31:0] rn, input logic ri,
                               input logic [1:0] al, input logic w, input logic [2:0] ls,
                               input logic fe, input logic bt, input logic jp,
                               input logic tr);
        out_t r;
        r = '{st: st, mreq: mr, ien: ie, pc_en: pe, ren: rn, roi: ri, alu: al, we: w,
              ls: ls, fen: fe, bt: bt, jmp: jp, trap: tr};
        return r;
    endfunction

    task automatic add(input logic [31:0] ins, input logic rdy, input logic [4:0] fl,
                       input out_t e);
        vec_t v;
        v.instr = ins; v.rdy = rdy; v.flags = fl; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d %h required st=%0d %h", name, act.st, act,
                     exp.st, exp);
        end else begin
            $display("ok   %s: st=%0d %h", name, act.st, act);
        end
    endtask

    // Fetch cycle that completes (ready) and one that stalls.
    function automatic out_t f_rdy();  return o(0,1,1,0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic out_t f_wait(); return o(0,1,0,0,0,0,0,0,0,0,0,0,0); endfunction
    function automatic out_t d_idle(); return o(1,0,0,0,0,0,0,0,0,0,0,0,0); endfunction

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_LW   = 32'h02A0A183; // lw   x3,42(x1)
    localparam logic [31:0] I_SW   = 32'h0020A423; // sw   x2,8(x1)
    localparam logic [31:0] I_BLT  = 32'h0020C063;
    localparam logic [31:0] I_BGE  = 32'h0020D063;
    localparam logic [31:0] I_BGEU = 32'h0020F063;
    localparam logic [31:0] I_ECAL = 32'h00000073;
    localparam logic [31:0] I_BAD  = 32'h000001FF; // opcode 0x7F, rd=x3
    localparam logic [31:0] I_JAL0 = 32'h0000006F; // jal x0
    localparam logic [31:0] I_JAL1 = 32'h000000EF; // jal x1
    localparam logic [31:0] I_LUI5 = 32'h000002B7; // lui x5
    localparam logic [31:0] I_LDX  = 32'h00003183; // load funct3=011
    localparam logic [31:0] I_BX   = 32'h00002063; // branch funct3=010
    localparam logic [31:0] I_FEN  = 32'h0000000F; // fence

    initial begin
        rst = 1'b1; instr = 32'h0; mem_ready = 1'b1; flags = 5'h0;

        // ADD x3,x1,x2
        add(I_ADD, 1, 0, f_rdy());
        add(I_ADD, 1, 0, d_idle());
        add(I_ADD, 1, 0, o(2,0,0,1,32'h8,0,0,0,0,0,0,0,0));
        // LW x3,42(x1) with two stalled MEM cycles
        add(I_LW, 1, 0, f_rdy());
        add(I_LW, 1, 0, d_idle());
        add(I_LW, 0, 0, o(3,1,0,0,0,1,0,0,3'b010,0,0,0,0));
        add(I_LW, 0, 0, o(3,1,0,0,0,1,0,0,3'b010,0,0,0,0));
        add(I_LW, 1, 0, o(3,1,0,0,0,1,0,0,3'b010,0,0,0,0));
        add(I_LW, 1, 0, o(4,0,0,1,32'h8,0,0,0,3'b010,0,0,0,0));
        // SW with FETCH stalled 3 cycles and one MEM stall
        add(I_SW, 0, 0, f_wait());
        add(I_SW, 0, 0, f_wait());
        add(I_SW, 0, 0, f_wait());
        add(I_SW, 1, 0, f_rdy());
        add(I_SW, 1, 0, d_idle());
        add(I_SW, 0, 0, o(3,1,0,0,0,1,0,1,3'b010,0,0,0,0));
        add(I_SW, 1, 0, o(3,1,0,1,0,1,0,1,3'b010,0,0,0,0));
        // BLT N=1,V=0 -> taken
        add(I_BLT, 1, 5'b00010, f_rdy());
        add(I_BLT, 1, 5'b00010, o(1,0,0,0,0,0,0,0,0,1,0,0,0));
        add(I_BLT, 1, 5'b00010, o(2,0,0,1,0,0,0,0,0,0,1,0,0));
        // BGEU C=0 -> not taken
        add(I_BGEU, 1, 5'b00000, f_rdy());
        add(I_BGEU, 1, 5'b00000, o(1,0,0,0,0,0,0,0,0,1,0,0,0));
        add(I_BGEU, 1, 5'b00000, o(2,0,0,1,0,0,0,0,0,0,0,0,0));
        // BGE N=1,V=1 -> taken
        add(I_BGE, 1, 5'b01010, f_rdy());
        add(I_BGE, 1, 5'b01010, o(1,0,0,0,0,0,0,0,0,1,0,0,0));
        add(I_BGE, 1, 5'b01010, o(2,0,0,1,0,0,0,0,0,0,1,0,0));
        // ECALL, then unknown opcode with rd=x3
        add(I_ECAL, 1, 0, f_rdy());
        add(I_ECAL, 1, 0, d_idle());
        add(I_ECAL, 1, 0, o(5,0,0,1,0,0,0,0,0,0,0,0,1));
        add(I_BAD, 1, 0, f_rdy());
        add(I_BAD, 1, 0, d_idle());
        add(I_BAD, 1, 0, o(5,0,0,1,0,0,0,0,0,0,0,0,1));
        // JAL x0 and JAL x1
        add(I_JAL0, 1, 0, f_rdy());
        add(I_JAL0, 1, 0, d_idle());
        add(I_JAL0, 1, 0, o(2,0,0,1,0,0,2'd1,0,0,0,0,1,0));
        add(I_JAL1, 1, 0, f_rdy());
        add(I_JAL1, 1, 0, d_idle());
        add(I_JAL1, 1, 0, o(2,0,0,1,32'h2,0,2'd1,0,0,0,0,1,0));
        // LUI x5 with mem_ready low outside FETCH (must be ignored)
        add(I_LUI5, 1, 0, f_rdy());
        add(I_LUI5, 0, 0, d_idle());
        add(I_LUI5, 0, 0, o(2,0,0,1,32'h20,1,2'd2,0,0,0,0,0,0));
        // Illegal load funct3 and illegal branch funct3 trap
        add(I_LDX, 1, 0, f_rdy());
        add(I_LDX, 1, 0, d_idle());
        add(I_LDX, 1, 0, o(5,0,0,1,0,0,0,0,0,0,0,0,1));
        add(I_BX, 1, 0, f_rdy());
        add(I_BX, 1, 0, o(1,0,0,0,0,0,0,0,0,1,0,0,0));
        add(I_BX, 1, 0, o(5,0,0,1,0,0,0,0,0,0,0,0,1));
        // FENCE is a NOP through EXECUTE
        add(I_FEN, 1, 0, f_rdy());
        add(I_FEN, 1, 0, d_idle());
        add(I_FEN, 1, 0, o(2,0,0,1,0,0,0,0,0,0,0,0,0));

        // Reset: outputs all zero with mem_ready high
        repeat (2) @(posedge clk);
        #1;
        check("reset_zero", o(0,0,0,0,0,0,0,0,0,0,0,0,0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            instr = vecs[i].instr; mem_ready = vecs[i].rdy; flags = vecs[i].flags;
            #1;
            check($sformatf("vec[%0d] instr=%h rdy=%0d", i, vecs[i].instr, vecs[i].rdy),
                  vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Reset during a stalled MEM store
        instr = I_SW; mem_ready = 1'b1;
        #1; check("rs_fetch", f_rdy());
        @(posedge clk); #1;
        check("rs_decode", d_idle());
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #1; check("rs_mem_stall", o(3,1,0,0,0,1,0,1,3'b010,0,0,0,0));
        rst = 1'b1;
        #1; check("rs_asserted", o(0,0,0,0,0,0,0,0,0,0,0,0,0));
        @(posedge clk); #1;
        rst = 1'b0;
        #1; check("rs_released", f_wait());
        mem_ready = 1'b1;
        #1; check("rs_restart", f_rdy());
        @(posedge clk); #1;
        check("rs_decode2", d_idle());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
